// File: rtl/lcd_refresh_scheduler.sv
// Shadow-buffered 16x2 LCD refresh sequencer: streams a 32-char frame as command/data beats to lcd_driver_8.
// Optional macro LCD_SCHED_HOME_EN prefixes every frame with a return-home (8'h02) command beat.
module lcd_refresh_scheduler #(
  parameter int unsigned REFRESH_CYCLES = 2_700_000,
  parameter logic [7:0]  LINE1_CMD      = 8'h80,
  parameter logic [7:0]  LINE2_CMD      = 8'hC0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       force_refresh,
  input  logic       lcd_ready,
  output logic       lcd_valid,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned      CNT_W    = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
`ifdef LCD_SCHED_HOME_EN
  localparam logic [7:0]       HOME_CMD = 8'h02;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_HOME, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2
  } state_t;

  logic [31:0][7:0] r_buf;
  logic             r_dirty;
  logic             r_pend_force;
  logic [CNT_W-1:0] r_tick_cnt;
  state_t           r_state;
  logic [4:0]       r_idx;
  logic             r_valid;
  logic             r_rs;
  logic [7:0]       r_data;
  logic             r_frame_done;

  logic             w_tick;
  logic             w_xfer;
  logic             w_start;
  logic             w_load;
  logic             w_done;
  state_t           w_state_nxt;
  logic [4:0]       w_idx_nxt;
  logic             w_nxt_rs;
  logic [7:0]       w_nxt_data;

  assign w_tick = (r_tick_cnt == CNT_LAST);
  assign w_xfer = r_valid && lcd_ready;

  // Free-running refresh timer; frames never pause it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + CNT_W'(1);
  end

  // Host-side shadow buffer; a write racing a frame start keeps dirty so it is repainted later.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
      r_dirty      <= 1'b1;
      r_pend_force <= 1'b0;
    end else begin
      if (wr_en) r_buf[wr_addr] <= wr_data;
      if (w_start)    r_dirty <= wr_en;
      else if (wr_en) r_dirty <= 1'b1;
      r_pend_force <= w_start ? 1'b0 : (r_pend_force | force_refresh);
    end
  end

  // Each transfer launches the following beat, capturing buffer data at launch.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_nxt_rs    = r_rs;
    w_nxt_data  = r_data;
    case (r_state)
      S_IDLE: begin
        if ((w_tick && r_dirty) || r_pend_force || force_refresh) begin
          w_start   = 1'b1;
          w_load    = 1'b1;
          w_idx_nxt = 5'd0;
          w_nxt_rs  = 1'b0;
`ifdef LCD_SCHED_HOME_EN
          w_state_nxt = S_HOME;
          w_nxt_data  = HOME_CMD;
`else
          w_state_nxt = S_ADDR1;
          w_nxt_data  = LINE1_CMD;
`endif
        end
      end
`ifdef LCD_SCHED_HOME_EN
      S_HOME: begin
        if (w_xfer) begin
          w_state_nxt = S_ADDR1;
          w_load      = 1'b1;
          w_nxt_rs    = 1'b0;
          w_nxt_data  = LINE1_CMD;
        end
      end
`endif
      S_ADDR1: begin
        if (w_xfer) begin
          w_state_nxt = S_LINE1;
          w_load      = 1'b1;
          w_nxt_rs    = 1'b1;
          w_nxt_data  = r_buf[r_idx];
          w_idx_nxt   = r_idx + 5'd1;
        end
      end
      S_LINE1: begin
        if (w_xfer) begin
          w_load = 1'b1;
          if (r_idx == 5'd16) begin
            w_state_nxt = S_ADDR2;
            w_nxt_rs    = 1'b0;
            w_nxt_data  = LINE2_CMD;
          end else begin
            w_nxt_rs   = 1'b1;
            w_nxt_data = r_buf[r_idx];
            w_idx_nxt  = r_idx + 5'd1;
          end
        end
      end
      S_ADDR2: begin
        if (w_xfer) begin
          w_state_nxt = S_LINE2;
          w_load      = 1'b1;
          w_nxt_rs    = 1'b1;
          w_nxt_data  = r_buf[r_idx];
          w_idx_nxt   = r_idx + 5'd1;
        end
      end
      S_LINE2: begin
        // Index wraps to 0 once char 31 has been launched.
        if (w_xfer) begin
          if (r_idx == 5'd0) begin
            w_state_nxt = S_IDLE;
            w_done      = 1'b1;
          end else begin
            w_load     = 1'b1;
            w_nxt_rs   = 1'b1;
            w_nxt_data = r_buf[r_idx];
            w_idx_nxt  = r_idx + 5'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= 5'd0;
      r_valid      <= 1'b0;
      r_rs         <= 1'b0;
      r_data       <= 8'h00;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_rs         <= w_nxt_rs;
      r_data       <= w_nxt_data;
      r_frame_done <= w_done;
      if (w_load)      r_valid <= 1'b1;
      else if (w_xfer) r_valid <= 1'b0;
    end
  end

  assign lcd_valid  = r_valid;
  assign lcd_rs     = r_rs;
  assign lcd_data   = r_data;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;

endmodule

// File: doc/lcd_refresh_scheduler.md
# lcd_refresh_scheduler

Frame-buffered refresh scheduler for the 16x2 SC1602 character LCD. It holds a 32-character shadow buffer that host logic writes at any time. On a periodic tick, or on demand, it sequences the buffer out to `lcd_driver_8` as a stream of command and data beats. It sits between application logic and the driver in `top`, replacing the driver's hard-wired data input.

## Interface
- `REFRESH_CYCLES`, default 2_700_000: tick period in `sys_clk` cycles (100 ms at 27 MHz); must be ≥ 2.
- `LINE1_CMD`, default 8'h80: DDRAM set-address command for line 1.
- `LINE2_CMD`, default 8'hC0: DDRAM set-address command for line 2.

Ports:
- `sys_clk`  in  1  clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  host write strobe, one buffer write per cycle.
- `wr_addr`  in  5  {line, col[3:0]}; 0–15 is line 1, 16–31 is line 2.
- `wr_data`  in  8  character code.
- `force_refresh`  in  1  request an immediate frame.
- `lcd_ready`  in  1  driver can accept a beat.
- `lcd_valid`  out  1  beat valid.
- `lcd_rs`  out  1  0 = command, 1 = character data.
- `lcd_data`  out  8  beat payload.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  single-cycle pulse at end of frame.

## Operation
- Buffer: 32 x 8 registers, all reset to 8'h20 (space). `wr_en` writes `wr_data` to `buffer[wr_addr]` on the clock edge and sets `dirty`. Writes are accepted in every state.
- `dirty` resets to 1, so the first tick after reset paints a blank screen.
- Tick timer: free-running counter over 0..REFRESH_CYCLES-1 that wraps to 0. `tick` is asserted in the cycle the counter equals REFRESH_CYCLES-1. The timer is never stopped by a frame.
- `pend_force`: set by `force_refresh`, cleared when a frame starts. A force request during a frame therefore yields exactly one further frame.
- Start condition, evaluated in IDLE only: (`tick` && `dirty`) || `pend_force` || `force_refresh`.
- On start, `dirty` clears unless `wr_en` is high in the same cycle, in which case `dirty` stays 1.
- FSM states:
  - IDLE: wait for the start condition, then go to ADDR1.
  - ADDR1: send rs=0, LINE1_CMD, then go to LINE1.
  - LINE1: send rs=1, `buffer[0..15]`, then go to ADDR2.
  - ADDR2: send rs=0, LINE2_CMD, then go to LINE2.
  - LINE2: send rs=1, `buffer[16..31]`, then go to IDLE and pulse `frame_done`.
- A 5-bit character index walks 0..31; it is reset to 0 on frame start.
- Handshake:
  - A beat transfers on a rising edge where `lcd_valid && lcd_ready`.
  - Once `lcd_valid` is asserted, `lcd_rs` and `lcd_data` stay constant until transfer.
  - `lcd_data` is captured from the buffer at beat launch. A host write to that position during the beat does not alter the beat; it sets `dirty` instead.
  - After a transfer, the next beat is presented in the following cycle, so back-to-back transfers sustain 1 beat per cycle when `lcd_ready` is held high.
- `busy` is 1 in every state except IDLE.
- Reset mid-frame aborts immediately. All outputs return to reset values and the buffer returns to spaces; no partial beat is completed.

## Timing
- Reset values: `lcd_valid`=0, `lcd_rs`=0, `lcd_data`=8'h00, `busy`=0, `frame_done`=0.
- If the start condition is true at edge N, then `busy`=1 and `lcd_valid`=1 with the ADDR1 beat (rs=0, data=LINE1_CMD) from cycle N+1.
- A frame is 34 beats (35 with the macro below). With `lcd_ready` tied to 1, the last transfer occurs at edge N+34.
- `frame_done`=1 for the single cycle after the last transfer. `busy` and `lcd_valid` are 0 in that same cycle.
- A new frame can start at the earliest one cycle after `frame_done` (i.e. when IDLE is re-entered).
- Simultaneous `tick` with `dirty`=0 and no force request: no frame starts.

## Configuration
- `LCD_SCHED_HOME_EN`: when defined, each frame begins with an extra HOME state that sends rs=0, 8'h02 (return home) before ADDR1. The frame is then 35 beats and `frame_done` moves one beat later. When undefined, a frame starts directly at ADDR1 (34 beats).

## Test plan
- Reset, REFRESH_CYCLES=16, `lcd_ready`=1: the first frame starts at tick 1 and emits 80, then 16×20 (rs=1), then C0, then 16×20; `frame_done` fires once; no second frame follows while `dirty`=0.
- Write 8'h52 to addr 0 and 8'h41 to addr 31, then `force_refresh`: beat 1 data is 52 and beat 33 data is 41, the rest are 20; `lcd_valid` rises one cycle after `force_refresh`.
- Randomly toggle `lcd_ready` with roughly 30% stalls: every beat holds rs/data stable while stalled; the beat count per frame is exactly 34.
- Write addr 5 during beat 3 of a frame: the current frame shows the old value; `dirty`=1 after `frame_done`; the next tick runs a frame showing the new value.
- `force_refresh` pulsed twice mid-frame: exactly one extra frame follows immediately after `frame_done`.
- Assert `sys_rst_n`=0 mid-LINE1: outputs read 0 asynchronously, the buffer reads back spaces, and after release the first tick repaints a blank screen.
